noc_input_port: RTL and testbench
=================================

// Module: noc_input_port
// PURPOSE
//  Router input stage, one instance per input port, upstream of the per-output rr_arbiter.
//  Buffers incoming single-flit spike packets in a FIFO and computes the XY-routed output port
//  of the head flit. Drives a one-hot request towards the output arbiters, and pops and
//  forwards the head flit when its request is granted.
// PARAMETERS
//  NUM_PORTS   5    output ports: 0=Local, 1=North(+Y), 2=East(+X), 3=South(-Y), 4=West(-X)
//  FLIT_WIDTH  32   flit width; dest X = flit[31:28], dest Y = flit[27:24]
//  DEPTH       4    FIFO entries; power of 2, >=2
//  ROUTER_X    0    this router's X coordinate (4-bit unsigned)
//  ROUTER_Y    0    this router's Y coordinate (4-bit unsigned)
// PORTS
//  clk        in   1               clock; one clock domain, all logic on posedge
//  rst        in   1               reset; synchronous, active-high
//  in_flit    in   FLIT_WIDTH      flit from link / local core
//  in_valid   in   1               in_flit valid
//  in_ready   out  1               space available; push = in_valid & in_ready
//  route_req  out  NUM_PORTS       one-hot request for head flit's output port; all-0 if empty
//  grant      in   1               this port granted by the arbiter of the requested output
//  out_flit   out  FLIT_WIDTH      registered forwarded flit
//  out_valid  out  1               registered; 1-cycle pulse per forwarded flit
//  out_port   out  NUM_PORTS       registered one-hot output port of out_flit
//  fwd_count  out  16              forwarded-flit counter, wraps 0xFFFF->0
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset (rst=1 at posedge): rd/wr pointers=0, count=0, out_valid=0, out_flit=0, out_port=0,
//    fwd_count=0. Consequently in_ready=1 and route_req=0 from the first cycle after reset.
//    FIFO contents are not cleared. A reset mid-operation discards all buffered flits.
//  - FIFO: count is clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
//    in_ready = (count != DEPTH) and depends on count only, never on grant (no comb path).
//    A push while full cannot occur (in_ready=0). in_valid with in_ready=0 is held by the sender.
//  - Pop = grant & (count != 0). A grant while empty is ignored and changes no state.
//    Push and pop in the same cycle: count unchanged; both pointers advance.
//  - Route (combinational from head entry, valid only when count != 0):
//    dx>ROUTER_X -> East; dx<ROUTER_X -> West; else dy>ROUTER_Y -> North;
//    dy<ROUTER_Y -> South; else Local. X is resolved fully before Y (deadlock-free XY).
//    route_req = one-hot(port) when count != 0, else 0.
//    Once asserted, route_req holds until the grant pops the flit.
//  - Latency: a push into an empty FIFO at edge N raises route_req after edge N.
//    A grant in cycle C pops at edge C+1, and out_valid/out_flit/out_port are valid
//    in cycle C+1 for exactly 1 cycle.
//  - Back-to-back: the new head's route_req is presented in the cycle following a pop,
//    so one flit per cycle is sustainable while grants continue.
//  - out_valid=0 in any cycle without a pop; out_flit/out_port hold their last value.
//  - fwd_count increments by 1 on every pop, with modulo-2^16 wrap.
// TESTING
//  1 Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=1, route_req=0, out_valid=0,
//    fwd_count=0, and no flit is accepted.
//  2 ROUTER=(1,1); push 0x3100_00AA -> next cycle route_req=5'b00100 (East). Grant 1 cycle ->
//    next cycle out_valid=1, out_flit=0x3100_00AA, out_port=5'b00100, fwd_count=1.
//  3 Route coverage at (1,1): dest (0,2)->W 5'b10000, (1,2)->N 5'b00010,
//    (1,0)->S 5'b01000, (1,1)->Local 5'b00001.
//  4 Full/stall: push 5 flits, grant=0 -> in_ready=0 after the 4th push; the 5th is held.
//    Then grant for 4 cycles -> 4 consecutive out_valid pulses in FIFO order, and in_ready=1
//    after the first pop.
//  5 Simultaneous push+pop at count=2 over 10 cycles -> count stays 2; pointer wrap is correct;
//    output order equals input order; grant while empty -> no out_valid.
//  6 Reset mid-operation with 3 flits buffered -> route_req=0 and in_ready=1 next cycle,
//    and no stale flit is forwarded afterwards. fwd_count wrap: preload via 65536 pops -> reads 0.

Source files
------------

// File: rtl/noc_input_port.sv
// Router input port: buffers single-flit packets in a FIFO, XY-routes the head flit,
// requests its output port and forwards the flit through a register stage when granted.
`timescale 1ns/1ps
module noc_input_port #(
  parameter int NUM_PORTS  = 5,
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_PORTS-1:0]  route_req,
  input  logic                  grant,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  output logic [NUM_PORTS-1:0]  out_port,
  output logic [15:0]           fwd_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [3:0] RX = 4'(ROUTER_X);
  localparam logic [3:0] RY = 4'(ROUTER_Y);

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop, not_empty;
  logic [FLIT_WIDTH-1:0] head_flit_p0;
  logic [NUM_PORTS-1:0]  head_port_p0;

  logic [FLIT_WIDTH-1:0] flit_p1;
  logic [NUM_PORTS-1:0]  port_p1;
  logic                  vld_p1;
  logic [15:0]           fwd_cnt;

  // X is settled completely before Y is considered, which keeps the mesh deadlock-free.
  function automatic logic [NUM_PORTS-1:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    if (dx > RX)      oh[P_EAST]  = 1'b1;
    else if (dx < RX) oh[P_WEST]  = 1'b1;
    else if (dy > RY) oh[P_NORTH] = 1'b1;
    else if (dy < RY) oh[P_SOUTH] = 1'b1;
    else              oh[P_LOCAL] = 1'b1;
    return oh;
  endfunction

  assign not_empty = (count != '0);
  assign in_ready  = (count != FULL);
  assign push      = in_valid & in_ready;
  assign pop       = grant & not_empty;

  // Stage p0: head of FIFO and its combinational route
  assign head_flit_p0 = mem[rd_ptr];
  assign head_port_p0 = xy_route(head_flit_p0[FLIT_WIDTH-1 -: 4], head_flit_p0[FLIT_WIDTH-5 -: 4]);
  assign route_req    = not_empty ? head_port_p0 : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      fwd_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      vld_p1 <= pop;
      if (pop) fwd_cnt <= fwd_cnt + 16'd1;
    end
  end

  // Stage p1: registered forwarded flit, held between pops
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_p1 <= '0;
      port_p1 <= '0;
    end else if (pop) begin
      flit_p1 <= head_flit_p0;
      port_p1 <= head_port_p0;
    end
  end

  assign out_flit  = flit_p1;
  assign out_port  = port_p1;
  assign out_valid = vld_p1;
  assign fwd_count = fwd_cnt;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port at router (1,1); a scoreboard queue of expected
// forwarded flits is consumed by a monitor that fires on every out_valid pulse.
`timescale 1ns/1ps
module tb_noc_input_port;

  localparam logic [4:0] LOC = 5'b00001;
  localparam logic [4:0] N   = 5'b00010;
  localparam logic [4:0] E   = 5'b00100;
  localparam logic [4:0] S   = 5'b01000;
  localparam logic [4:0] W   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  route_req;
  logic        grant = 1'b0;
  logic [31:0] out_flit;
  logic        out_valid;
  logic [4:0]  out_port;
  logic [15:0] fwd_count;

  typedef struct packed {
    logic [4:0]  port;
    logic [31:0] flit;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_fwd = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  noc_input_port #(
    .NUM_PORTS(5), .FLIT_WIDTH(32), .DEPTH(4), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .route_req(route_req), .grant(grant), .out_flit(out_flit), .out_valid(out_valid),
    .out_port(out_port), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a flit, wait (bounded) for space, record the expectation, complete the push.
  task automatic push_flit(input logic [31:0] f, input logic [4:0] p);
    int waited;
    waited = 0;
    in_flit  = f;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      cyc();
      waited++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    sb.push_back('{port: p, flit: f});
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic route_case(input string name, input logic [31:0] f, input logic [4:0] p);
    push_flit(f, p);
    check(name, 32'(route_req), 32'(p));
    grant = 1'b1;
    cyc();
    grant = 1'b0;
  endtask

  initial begin
    logic [15:0] pat_hi [4];
    logic [4:0]  pat_port [4];
    pat_hi[0] = 16'h3100; pat_port[0] = E;
    pat_hi[1] = 16'h0200; pat_port[1] = W;
    pat_hi[2] = 16'h1200; pat_port[2] = N;
    pat_hi[3] = 16'h1000; pat_port[3] = S;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_out: flit 0x%08h port %05b with nothing expected", out_flit, out_port);
            end else begin
              e = sb.pop_front();
              exp_fwd = exp_fwd + 16'd1;
              if (out_flit !== e.flit || out_port !== e.port || fwd_count !== exp_fwd) begin
                n_fail++;
                $display("FAIL fwd_flit: got flit 0x%08h port %05b cnt %0d, expected flit 0x%08h port %05b cnt %0d",
                         out_flit, out_port, fwd_count, e.flit, e.port, exp_fwd);
              end
            end
          end
        end
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    // 1: reset with in_valid asserted
    cyc();
    rst = 1'b1; in_valid = 1'b1; in_flit = 32'h3100_0077;
    cyc(); cyc();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_route_req", 32'(route_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fwd_count", 32'(fwd_count), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    check("rst_no_accept", 32'(route_req), 32'd0);

    // 2: single East flit
    push_flit(32'h3100_00AA, E);
    check("east_route_req", 32'(route_req), 32'(E));
    grant = 1'b1;
    cyc();
    grant = 1'b0;
    check("east_out_valid", 32'(out_valid), 32'd1);
    check("east_fwd_count", 32'(fwd_count), 32'd1);
    cyc();
    check("east_pulse_end", 32'(out_valid), 32'd0);
    check("east_empty", 32'(route_req), 32'd0);

    // 3: route coverage
    route_case("route_west",  32'h0200_0001, W);
    route_case("route_north", 32'h1200_0002, N);
    route_case("route_south", 32'h1000_0003, S);
    route_case("route_local", 32'h1100_0004, LOC);
    cyc();

    // 4: fill, stall fifth, then drain with consecutive grants
    for (int i = 0; i < 4; i++) push_flit(32'h3100_0010 + 32'(i), E);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_flit = 32'h0200_0015; in_valid = 1'b1;
    cyc();
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check("full_hold_req", 32'(route_req), 32'(E));
    cyc();
    sb.push_back('{port: W, flit: 32'h0200_0015});
    grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("burst_valid_%0d", i), 32'(out_valid), 32'd1);
      if (i == 0) check("burst_ready_after_pop", 32'(in_ready), 32'd1);
      if (i == 1) in_valid = 1'b0;
    end
    grant = 1'b0;
    check("burst_fifth_head", 32'(route_req), 32'(W));
    grant = 1'b1;
    cyc();
    grant = 1'b0;
    cyc();
    check("burst_drained", 32'(route_req), 32'd0);

    // 5: push and pop together at occupancy 2, wrapping pointers
    push_flit(32'h3100_0100, E);
    push_flit(32'h1200_0101, N);
    grant = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_flit = {pat_hi[i % 4], 16'h5000 + 16'(i)};
      sb.push_back('{port: pat_port[i % 4], flit: in_flit});
      cyc();
      if (in_ready !== 1'b1) check($sformatf("steady_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cyc(); cyc();
    check("steady_count_two", 32'(route_req), 32'd0);
    cyc();
    check("grant_empty_no_valid", 32'(out_valid), 32'd0);
    check("grant_empty_fwd", 32'(fwd_count), 32'(exp_fwd));
    grant = 1'b0;

    // 6: reset with three flits buffered
    push_flit(32'h3100_0200, E);
    push_flit(32'h3100_0201, E);
    push_flit(32'h3100_0202, E);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    exp_fwd = '0;
    check("midrst_route_req", 32'(route_req), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_fwd_count", 32'(fwd_count), 32'd0);
    grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("midrst_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end

    // fwd_count wrap after 65536 pops, streaming one flit per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_flit = {16'h1100, 16'(i)};
      sb.push_back('{port: LOC, flit: in_flit});
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("wrap_last_valid", 32'(out_valid), 32'd1);
    check("wrap_fwd_count", 32'(fwd_count), 32'd0);
    grant = 1'b0;
    cyc();
    check("wrap_empty", 32'(route_req), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
